qcs_rst_seq: RTL and testbench



---
 rtl/qcs_rst_seq_pkg.sv | 15 +
 rtl/qcs_rst_sync.sv | 22 ++
 rtl/qcs_rst_seq.sv | 138 +++++++++++++
 tb/tb_qcs_rst_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qcs_rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and a sizing helper.
package qcs_rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN,
        SW_ASSERT
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/qcs_rst_sync.sv
// Async-assert / sync-deassert reset synchroniser; output rises STAGES edges after release.
module qcs_rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rst_sync_n_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/qcs_rst_seq.sv
// Reset sequencer: releases NUM_OUT block resets one at a time after a synchronised
// power-on reset, and re-runs the sequence on a 4-phase software reset handshake.
module qcs_rst_seq
    import qcs_rst_seq_pkg::*;
#(
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STEP_DLY    = 16,
    parameter int unsigned SW_RST_MIN  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_rst_req,
    output logic               sw_rst_ack,
    output logic [NUM_OUT-1:0] rst_n_o,
    output logic [NUM_OUT-1:0] rst_o,
    output logic               rst_done
);

    localparam int unsigned CNT_W = $clog2(max_u(STEP_DLY, SW_RST_MIN) + 1);
    localparam int unsigned IDX_W = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] STEP_TC  = CNT_W'(STEP_DLY - 1);
    localparam logic [CNT_W-1:0] SW_TC    = CNT_W'(SW_RST_MIN - 1);
    localparam logic [CNT_W-1:0] SW_MAX   = CNT_W'(SW_RST_MIN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

    logic rst_sync_n;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [NUM_OUT-1:0] rst_n_o_q, rst_n_o_d;
    logic               ack_q,     ack_d;
    logic               done_q,    done_d;

    qcs_rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rst_sync_n_o (rst_sync_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_n_o_q <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_n_o_q <= rst_n_o_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_n_o_d = rst_n_o_q;
        ack_d     = ack_q;
        done_d    = done_q;

        unique case (state_q)
            HOLD: begin
                rst_n_o_d = '0;
                if (rst_sync_n) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            RELEASE: begin
                if (cnt_q == STEP_TC) begin
                    cnt_d = '0;
                    // Loop compare avoids indexing with the wider idx counter.
                    for (int unsigned k = 0; k < NUM_OUT; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            rst_n_o_d[k] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RUN: begin
                if (sw_rst_req) begin
                    state_d   = SW_ASSERT;
                    rst_n_o_d = '0;
                    done_d    = 1'b0;
                    cnt_d     = '0;
                end
            end

            SW_ASSERT: begin
                if (!sw_rst_req && ack_q) begin
                    state_d = RELEASE;
                    ack_d   = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    // Counting continues even if req drops early, so the ack still pulses.
                    if (cnt_q != SW_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == SW_TC) begin
                        ack_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = HOLD;
            end
        endcase
    end

    assign rst_n_o    = rst_n_o_q;
    assign rst_o      = ~rst_n_o_q;
    assign sw_rst_ack = ack_q;
    assign rst_done   = done_q;

endmodule

// File: tb/tb_qcs_rst_seq.sv
// Directed bench for qcs_rst_seq: default build plus a NUM_OUT=1, STEP_DLY=1 build.
module tb_qcs_rst_seq;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       sw_rst_ack;
    logic [3:0] rst_n_o;
    logic [3:0] rst_o;
    logic       rst_done;

    logic       rst2_n = 1'b1;
    logic       req2 = 1'b0;
    logic       ack2;
    logic [0:0] rst2_n_o;
    logic [0:0] rst2_o;
    logic       done2;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    qcs_rst_seq #(
        .NUM_OUT     (4),
        .SYNC_STAGES (2),
        .STEP_DLY    (16),
        .SW_RST_MIN  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_rst_req),
        .sw_rst_ack (sw_rst_ack),
        .rst_n_o    (rst_n_o),
        .rst_o      (rst_o),
        .rst_done   (rst_done)
    );

    qcs_rst_seq #(
        .NUM_OUT     (1),
        .SYNC_STAGES (2),
        .STEP_DLY    (1),
        .SW_RST_MIN  (8)
    ) dut_small (
        .clk        (clk),
        .rst_n      (rst2_n),
        .sw_rst_req (req2),
        .sw_rst_ack (ack2),
        .rst_n_o    (rst2_n_o),
        .rst_o      (rst2_o),
        .rst_done   (done2)
    );

    // Advance to edge e counted from the last deassertion; sample 1 ns after it.
    task automatic goto(input int e);
        if (e > cur) begin
            repeat (e - cur) @(posedge clk);
            #1;
            cur = e;
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        #2;
        total++; if (rst_n_o !== 4'b0000) begin bad++; $display("FAIL reset_rst_n_o got=%b exp=0000", rst_n_o); end
        total++; if (rst_o !== 4'b1111) begin bad++; $display("FAIL reset_rst_o got=%b exp=1111", rst_o); end
        total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", sw_rst_ack); end
        total++; if (rst_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", rst_done); end
        total++; if (rst2_n_o !== 1'b0 || done2 !== 1'b0) begin bad++; $display("FAIL reset_small got=%b/%b exp=0/0", rst2_n_o, done2); end
        clk_en = 1'b1;
    endtask

    task automatic test_power_on;
        repeat (10) @(posedge clk);
        #1;
        total++; if (rst_n_o !== 4'b0000 || rst_done !== 1'b0) begin bad++; $display("FAIL por_held got=%b/%b exp=0000/0", rst_n_o, rst_done); end
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
        goto(2);
        total++; if (rst_n_o !== 4'b0000) begin bad++; $display("FAIL por_e2 got=%b exp=0000", rst_n_o); end
        goto(18);
        total++; if (rst_n_o !== 4'b0000) begin bad++; $display("FAIL por_e18 got=%b exp=0000", rst_n_o); end
        goto(19);
        total++; if (rst_n_o !== 4'b0001) begin bad++; $display("FAIL por_e19 got=%b exp=0001", rst_n_o); end
        total++; if (rst_o !== 4'b1110) begin bad++; $display("FAIL por_e19_rst_o got=%b exp=1110", rst_o); end
        goto(34);
        total++; if (rst_n_o !== 4'b0001) begin bad++; $display("FAIL por_e34 got=%b exp=0001", rst_n_o); end
        goto(35);
        total++; if (rst_n_o !== 4'b0011) begin bad++; $display("FAIL por_e35 got=%b exp=0011", rst_n_o); end
        goto(50);
        total++; if (rst_n_o !== 4'b0011) begin bad++; $display("FAIL por_e50 got=%b exp=0011", rst_n_o); end
        goto(51);
        total++; if (rst_n_o !== 4'b0111) begin bad++; $display("FAIL por_e51 got=%b exp=0111", rst_n_o); end
        goto(66);
        total++; if (rst_n_o !== 4'b0111 || rst_done !== 1'b0) begin bad++; $display("FAIL por_e66 got=%b/%b exp=0111/0", rst_n_o, rst_done); end
        goto(67);
        total++; if (rst_n_o !== 4'b1111 || rst_done !== 1'b1) begin bad++; $display("FAIL por_e67 got=%b/%b exp=1111/1", rst_n_o, rst_done); end
        total++; if (rst_o !== 4'b0000) begin bad++; $display("FAIL por_e67_rst_o got=%b exp=0000", rst_o); end
    endtask

    task automatic test_sw_reset;
        sw_rst_req = 1'b1;
        goto(68);
        total++; if (rst_n_o !== 4'b0000 || rst_done !== 1'b0) begin bad++; $display("FAIL sw_assert got=%b/%b exp=0000/0", rst_n_o, rst_done); end
        goto(75);
        total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL sw_ack_e75 got=%b exp=0", sw_rst_ack); end
        goto(76);
        total++; if (sw_rst_ack !== 1'b1) begin bad++; $display("FAIL sw_ack_e76 got=%b exp=1", sw_rst_ack); end
        goto(78);
        total++; if (sw_rst_ack !== 1'b1 || rst_n_o !== 4'b0000) begin bad++; $display("FAIL sw_hold got=%b/%b exp=1/0000", sw_rst_ack, rst_n_o); end
        sw_rst_req = 1'b0;
        goto(79);
        total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL sw_ack_drop got=%b exp=0", sw_rst_ack); end
        goto(94);
        total++; if (rst_n_o !== 4'b0000) begin bad++; $display("FAIL sw_rel_e94 got=%b exp=0000", rst_n_o); end
        goto(95);
        total++; if (rst_n_o !== 4'b0001) begin bad++; $display("FAIL sw_rel_e95 got=%b exp=0001", rst_n_o); end
        goto(142);
        total++; if (rst_done !== 1'b0) begin bad++; $display("FAIL sw_done_e142 got=%b exp=0", rst_done); end
        goto(143);
        total++; if (rst_done !== 1'b1 || rst_n_o !== 4'b1111) begin bad++; $display("FAIL sw_done_e143 got=%b/%b exp=1/1111", rst_done, rst_n_o); end
    endtask

    task automatic test_midrelease_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
        goto(35);
        total++; if (rst_n_o !== 4'b0011) begin bad++; $display("FAIL mid_e35 got=%b exp=0011", rst_n_o); end
        goto(40);
        clk_en = 1'b0;
        #20;
        rst_n = 1'b0;
        #3;
        total++; if (rst_n_o !== 4'b0000 || rst_done !== 1'b0) begin bad++; $display("FAIL mid_async got=%b/%b exp=0000/0", rst_n_o, rst_done); end
        total++; if (rst_o !== 4'b1111) begin bad++; $display("FAIL mid_async_rst_o got=%b exp=1111", rst_o); end
        #10;
        rst_n = 1'b1;
        clk_en = 1'b1;
        cur = 0;
        goto(18);
        total++; if (rst_n_o !== 4'b0000) begin bad++; $display("FAIL mid_e18 got=%b exp=0000", rst_n_o); end
        goto(19);
        total++; if (rst_n_o !== 4'b0001) begin bad++; $display("FAIL mid_e19 got=%b exp=0001", rst_n_o); end
        goto(66);
        total++; if (rst_done !== 1'b0) begin bad++; $display("FAIL mid_e66 got=%b exp=0", rst_done); end
        goto(67);
        total++; if (rst_n_o !== 4'b1111 || rst_done !== 1'b1) begin bad++; $display("FAIL mid_e67 got=%b/%b exp=1111/1", rst_n_o, rst_done); end
    endtask

    task automatic test_glitch;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        total++; if (rst_n_o !== 4'b0000 || rst_done !== 1'b0) begin bad++; $display("FAIL glitch_async got=%b/%b exp=0000/0", rst_n_o, rst_done); end
        cur = 0;
        goto(18);
        total++; if (rst_n_o !== 4'b0000) begin bad++; $display("FAIL glitch_e18 got=%b exp=0000", rst_n_o); end
        goto(19);
        total++; if (rst_n_o !== 4'b0001) begin bad++; $display("FAIL glitch_e19 got=%b exp=0001", rst_n_o); end
        goto(67);
        total++; if (rst_n_o !== 4'b1111 || rst_done !== 1'b1) begin bad++; $display("FAIL glitch_e67 got=%b/%b exp=1111/1", rst_n_o, rst_done); end
    endtask

    task automatic test_req_from_hold;
        rst_n = 1'b0;
        sw_rst_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
        goto(19);
        total++; if (rst_n_o !== 4'b0001 || sw_rst_ack !== 1'b0) begin bad++; $display("FAIL hreq_e19 got=%b/%b exp=0001/0", rst_n_o, sw_rst_ack); end
        goto(66);
        total++; if (rst_n_o !== 4'b0111 || rst_done !== 1'b0 || sw_rst_ack !== 1'b0) begin bad++; $display("FAIL hreq_e66 got=%b/%b/%b exp=0111/0/0", rst_n_o, rst_done, sw_rst_ack); end
        goto(67);
        total++; if (rst_n_o !== 4'b1111 || rst_done !== 1'b1) begin bad++; $display("FAIL hreq_e67 got=%b/%b exp=1111/1", rst_n_o, rst_done); end
        goto(68);
        total++; if (rst_n_o !== 4'b0000 || rst_done !== 1'b0) begin bad++; $display("FAIL hreq_e68 got=%b/%b exp=0000/0", rst_n_o, rst_done); end
        goto(75);
        total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL hreq_ack_e75 got=%b exp=0", sw_rst_ack); end
        goto(76);
        total++; if (sw_rst_ack !== 1'b1) begin bad++; $display("FAIL hreq_ack_e76 got=%b exp=1", sw_rst_ack); end
        sw_rst_req = 1'b0;
        goto(77);
        total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL hreq_ack_e77 got=%b exp=0", sw_rst_ack); end
    endtask

    task automatic test_req_pulse;
        goto(141);
        total++; if (rst_done !== 1'b1 || rst_n_o !== 4'b1111) begin bad++; $display("FAIL pulse_run got=%b/%b exp=1/1111", rst_done, rst_n_o); end
        sw_rst_req = 1'b1;
        goto(142);
        total++; if (rst_done !== 1'b0 || rst_n_o !== 4'b0000) begin bad++; $display("FAIL pulse_assert got=%b/%b exp=0/0000", rst_done, rst_n_o); end
        goto(143);
        sw_rst_req = 1'b0;
        goto(149);
        total++; if (sw_rst_ack !== 1'b0) begin bad++; $display("FAIL pulse_ack_e149 got=%b exp=0", sw_rst_ack); end
        goto(150);
        total++; if (sw_rst_ack !== 1'b1) begin bad++; $display("FAIL pulse_ack_e150 got=%b exp=1", sw_rst_ack); end
        goto(151);
        total++; if (sw_rst_ack !== 1'b0 || rst_n_o !== 4'b0000) begin bad++; $display("FAIL pulse_ack_e151 got=%b/%b exp=0/0000", sw_rst_ack, rst_n_o); end
        goto(166);
        total++; if (rst_n_o !== 4'b0000) begin bad++; $display("FAIL pulse_e166 got=%b exp=0000", rst_n_o); end
        goto(167);
        total++; if (rst_n_o !== 4'b0001) begin bad++; $display("FAIL pulse_e167 got=%b exp=0001", rst_n_o); end
    endtask

    task automatic test_small_build;
        @(negedge clk);
        rst2_n = 1'b1;
        cur = 0;
        goto(3);
        total++; if (rst2_n_o !== 1'b0 || done2 !== 1'b0) begin bad++; $display("FAIL small_e3 got=%b/%b exp=0/0", rst2_n_o, done2); end
        goto(4);
        total++; if (rst2_n_o !== 1'b1 || done2 !== 1'b1) begin bad++; $display("FAIL small_e4 got=%b/%b exp=1/1", rst2_n_o, done2); end
        total++; if (rst2_o !== 1'b0) begin bad++; $display("FAIL small_rst_o got=%b exp=0", rst2_o); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_sw_reset();
        test_midrelease_reset();
        test_glitch();
        test_req_from_hold();
        test_req_pulse();
        test_small_build();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
